// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ
// valid/ready requesters, with bounded bursts and full back-pressure.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic                     i_full,
    output logic                     o_winc,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_busy,
    output logic [ID_W-1:0]          o_grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_gnt;
    logic [ID_W-1:0]  w_gnt_nxt;
    logic [ID_W-1:0]  r_last;
    logic [ID_W-1:0]  w_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [WIDTH-1:0]   w_req_data [NUM_REQ];
    logic               w_busy;
    logic               w_gnt_valid;
    logic               w_accept;
    logic               w_release;
    logic [NUM_REQ-1:0] w_others;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign w_req_data[k] = i_req_data[k*WIDTH +: WIDTH];
    end

    // First set bit of mask scanning upward from base+1, wrapping.
    function automatic logic [ID_W-1:0] f_pick(
        input logic [NUM_REQ-1:0] mask,
        input logic [ID_W-1:0]    base
    );
        logic [ID_W-1:0] res;
        logic [ID_W-1:0] idx;
        logic            found;
        res   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(base) + i) % NUM_REQ);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_busy      = (r_state == S_GRANT);
    assign w_gnt_valid = i_req_valid[r_gnt];
    assign w_accept    = w_busy & w_gnt_valid & ~i_full;
    assign w_release   = ~w_gnt_valid |
                         (w_accept & (r_cnt == CNT_W'(MAX_BURST - 1)));
    assign w_others    = i_req_valid & ~(NUM_REQ'(1) << r_gnt);

    assign o_busy     = w_busy;
    assign o_grant_id = r_gnt;
    assign o_winc     = w_accept;
    assign o_data     = w_busy ? w_req_data[r_gnt] : '0;

    always_comb begin
        o_req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_req_ready[k] = w_busy & (r_gnt == ID_W'(k)) & ~i_full;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (|i_req_valid) begin
                    w_gnt_nxt   = f_pick(i_req_valid, r_last);
                    w_state_nxt = S_GRANT;
                    w_cnt_nxt   = '0;
                end
            end
            S_GRANT: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                // Hand over with no bubble; self re-grant if uncontended.
                if (w_release) begin
                    w_last_nxt = r_gnt;
                    if (|w_others) begin
                        w_gnt_nxt = f_pick(w_others, r_gnt);
                        w_cnt_nxt = '0;
                    end else if (w_gnt_valid) begin
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_last  <= ID_W'(NUM_REQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized run,
// with per-requester order scoreboard and a rule-level arbitration model.
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int MB  = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   ready;
    logic           full;
    logic           winc;
    logic [W-1:0]   odata;
    logic           busy;
    logic [IDW-1:0] gid;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB), .ID_W(IDW)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_req_valid(valid),
        .i_req_data(data),
        .o_req_ready(ready),
        .i_full(full),
        .o_winc(winc),
        .o_data(odata),
        .o_busy(busy),
        .o_grant_id(gid)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] exp_q [N][$];
    int           seq [N];
    logic [N-1:0] ven;

    int m_busy, m_gnt, m_last, m_cnt;
    int wt [N];

    logic           d_winc;
    logic           d_busy;
    logic [IDW-1:0] d_gid;
    logic [N-1:0]   d_ready;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] item(input int k);
        return W'((k << 6) | (seq[k] & 63));
    endfunction

    function automatic int pick(input logic [N-1:0] m, input int base);
        for (int i = 1; i <= N; i++) begin
            if (m[(base + i) % N]) return (base + i) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_gnt  = 0;
        m_last = N - 1;
        m_cnt  = 0;
        for (int k = 0; k < N; k++) wt[k] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid = '0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive, check against model, advance model and requesters.
    task automatic cycle(input bit fair);
        logic [N-1:0] e_ready, xfer, oth;
        logic [W-1:0] e_data;
        bit           e_winc, rel;
        int           nb, ng, nl, nc;
        @(negedge clk);
        valid = ven;
        for (int k = 0; k < N; k++) data[k*W +: W] = item(k);
        #1;
        e_winc  = (m_busy != 0) && valid[m_gnt] && !full;
        e_ready = '0;
        if (m_busy != 0 && !full) e_ready[m_gnt] = 1'b1;
        e_data  = (m_busy != 0) ? item(m_gnt) : '0;
        chk("busy", int'(busy), m_busy);
        chk("grant_id", int'(gid), m_gnt);
        chk("winc", int'(winc), int'(e_winc));
        chk("ready", int'(ready), int'(e_ready));
        chk("data", int'(odata), int'(e_data));
        d_winc = winc; d_busy = busy; d_gid = gid; d_ready = ready;
        xfer = valid & ready;
        if (fair) begin
            for (int k = 0; k < N; k++) begin
                if (!valid[k] || (winc && int'(gid) == k)) wt[k] = 0;
                else if (winc) begin
                    wt[k]++;
                    chk("fair_wait", int'(wt[k] <= (N - 1) * MB), 1);
                end
            end
        end
        nb = m_busy; ng = m_gnt; nl = m_last; nc = m_cnt;
        if (m_busy == 0) begin
            if (valid != 0) begin
                nb = 1; ng = pick(valid, m_last); nc = 0;
            end
        end else begin
            rel = !valid[m_gnt] || (e_winc && m_cnt == MB - 1);
            if (e_winc) nc = m_cnt + 1;
            if (rel) begin
                nl = m_gnt;
                oth = valid;
                oth[m_gnt] = 1'b0;
                if (oth != 0) begin
                    ng = pick(oth, m_gnt); nc = 0;
                end else if (valid[m_gnt]) nc = 0;
                else nb = 0;
            end
        end
        @(posedge clk);
        #1;
        m_busy = nb; m_gnt = ng; m_last = nl; m_cnt = nc;
        for (int k = 0; k < N; k++) begin
            if (xfer[k]) begin
                seq[k]++;
                exp_q[k].push_back(item(k));
            end
        end
    endtask

    // Scoreboard monitor: every committed write pops its requester's queue.
    always begin : monitor
        logic [W-1:0]   val;
        logic [IDW-1:0] g;
        int             id;
        logic           f;
        @(negedge clk);
        #2;
        if (rst_n && winc) begin
            val = odata;
            id  = int'(odata[7:6]);
            g   = gid;
            f   = full;
            @(posedge clk or negedge rst_n);
            if (rst_n) begin
                chk("winc_while_full", int'(f), 0);
                chk("src_id", id, int'(g));
                if (exp_q[id].size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL order: req%0d wrote %h with nothing expected", id, val);
                end else begin
                    chk("order", int'(val), int'(exp_q[id].pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        valid = '0;
        data  = '0;
        full  = 1'b0;
        ven   = '0;
        for (int k = 0; k < N; k++) seq[k] = 0;
        seq[0] = 17;
        for (int k = 0; k < N; k++) exp_q[k].push_back(item(k));
        model_reset();
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_winc", int'(winc), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_gid", int'(gid), 0);
        chk("rst_data", int'(odata), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, 6 beats 0x11..0x16, self re-grant after 4.
        ven = 4'b0001;
        cycle(0);
        chk("s1_idle", int'(d_busy), 0);
        for (int c = 1; c <= 6; c++) begin
            cycle(0);
            chk("s1_winc", int'(d_winc), 1);
            chk("s1_gid", int'(d_gid), 0);
        end
        chk("s1_seq_done", seq[0], 23);
        ven = '0;
        cycle(0);
        chk("s1_drop_winc", int'(d_winc), 0);
        cycle(0);
        chk("s1_back_idle", int'(d_busy), 0);

        // All four contending: 0,1,2,3,0 in bursts of 4, no gaps.
        do_reset();
        ven = 4'b1111;
        cycle(0);
        for (int c = 1; c <= 20; c++) begin
            cycle(0);
            chk("rr_gid", int'(d_gid), ((c - 1) / MB) % N);
            chk("rr_winc", int'(d_winc), 1);
        end

        // Full pulse for 5 cycles inside req1's burst.
        do_reset();
        ven = 4'b0110;
        cycle(0);
        for (int c = 1; c <= 10; c++) begin
            full = (c >= 3 && c <= 7);
            cycle(0);
            if (c >= 3 && c <= 7) begin
                chk("full_winc", int'(d_winc), 0);
                chk("full_ready", int'(d_ready), 0);
                chk("full_gid", int'(d_gid), 1);
            end else begin
                chk("full_winc_on", int'(d_winc), 1);
                chk("full_gid_on", int'(d_gid), (c == 10) ? 2 : 1);
            end
        end
        full = 1'b0;

        // Early release of req2 hands over to 3, not 0.
        do_reset();
        ven = 4'b0100;
        cycle(0);
        cycle(0);
        chk("er_first", int'(d_gid), 2);
        ven = 4'b1001;
        cycle(0);
        chk("er_drop_winc", int'(d_winc), 0);
        for (int c = 0; c < MB; c++) begin
            cycle(0);
            chk("er_gid3", int'(d_gid), 3);
            chk("er_winc", int'(d_winc), 1);
        end
        cycle(0);
        chk("er_next0", int'(d_gid), 0);

        // Asynchronous reset during req3's second beat.
        do_reset();
        ven = 4'b1111;
        for (int c = 0; c < 14; c++) cycle(0);
        @(negedge clk);
        #1;
        chk("mr_pre_winc", int'(winc), 1);
        chk("mr_pre_gid", int'(gid), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_winc", int'(winc), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_ready", int'(ready), 0);
        valid = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0);
        cycle(0);
        chk("mr_prio0", int'(d_gid), 0);
        chk("mr_busy_on", int'(d_busy), 1);

        // Randomized run.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < N; k++) ven[k] = ($urandom_range(0, 3) != 0);
            full = ($urandom_range(0, 4) == 0);
            cycle(1);
        end
        full = 1'b0;
        ven  = '0;
        cycle(0);
        cycle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
